// File: rtl/rgb_seq_pkg.sv
// Shared types and constants for the RGB colour-fade sequencer:
// duty/index widths, the four-colour palette, state encodings and
// the per-channel "one count toward target" step helper.
package rgb_seq_pkg;

  localparam int DUTY_W     = 8;
  localparam int NUM_COLORS = 4;
  localparam int IDX_W      = 2;

  // Palette entries packed as {red, green, blue}
  localparam logic [3*DUTY_W-1:0] PAL_RED   = 24'hFF0000;
  localparam logic [3*DUTY_W-1:0] PAL_GREEN = 24'h00FF00;
  localparam logic [3*DUTY_W-1:0] PAL_BLUE  = 24'h0000FF;
  localparam logic [3*DUTY_W-1:0] PAL_WHITE = 24'hFFFFFF;

  // Encodings are visible on o_state, so they are pinned explicitly
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FADE = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_t;

  // Palette lookup by colour index
  function automatic logic [3*DUTY_W-1:0] palette_color(input logic [IDX_W-1:0] idx);
    logic [3*DUTY_W-1:0] color;
    case (idx)
      2'd0:    color = PAL_RED;
      2'd1:    color = PAL_GREEN;
      2'd2:    color = PAL_BLUE;
      default: color = PAL_WHITE;
    endcase
    return color;
  endfunction

  // Move one count toward the target; equal values stay put, so a
  // channel can never overshoot or wrap
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    logic [DUTY_W-1:0] nxt;
    if (cur < tgt) begin
      nxt = cur + DUTY_W'(1);
    end else if (cur > tgt) begin
      nxt = cur - DUTY_W'(1);
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_tick_gen.sv
// Fade-step prescaler: counts enabled clocks modulo TICK_DIV and flags
// the edge on which the count wraps. The tick is decoded from the
// current count so the sequencer acts on that very edge.
module tick_gen #(
  parameter int TICK_DIV = 46875
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == CNT_LAST);

  // Prescale counter: held at zero while cleared, frozen while disabled
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// RGB colour-fade sequencer. Walks the palette red -> green -> blue ->
// white -> red, fading each channel linearly one count per step, then
// holding each colour for HOLD_TICKS steps. Drives three 8-bit PWM duty
// words; LED pin inversion is left to the board top.
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int TICK_DIV   = 46875,
  parameter int HOLD_TICKS = 256
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_next,
  output logic [7:0]       o_duty_r,
  output logic [7:0]       o_duty_g,
  output logic [7:0]       o_duty_b,
  output logic [1:0]       o_color_idx,
  output logic [1:0]       o_state,
  output logic             o_step
);

  localparam int HOLD_W = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  seq_state_t          state;
  logic [DUTY_W-1:0]   duty_r;
  logic [DUTY_W-1:0]   duty_g;
  logic [DUTY_W-1:0]   duty_b;
  logic [IDX_W-1:0]    color_idx;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                step;

  logic                run;
  logic                tick;
  logic [3*DUTY_W-1:0] target;
  logic [DUTY_W-1:0]   next_r;
  logic [DUTY_W-1:0]   next_g;
  logic [DUTY_W-1:0]   next_b;
  logic                fade_done;
  logic                hold_expired;
  logic                advance;

  // The prescaler only runs outside IDLE, and is pinned to zero in IDLE
  assign run = i_enable && (state != ST_IDLE);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (i_clk),
    .reset  (i_reset),
    .clear  (state == ST_IDLE),
    .enable (run),
    .tick   (tick)
  );

  // Per-channel step units, one repeated expression per colour
  assign target = palette_color(color_idx);
  assign next_r = step_toward(duty_r, target[3*DUTY_W-1:2*DUTY_W]);
  assign next_g = step_toward(duty_g, target[2*DUTY_W-1:DUTY_W]);
  assign next_b = step_toward(duty_b, target[DUTY_W-1:0]);
  assign fade_done = ({next_r, next_g, next_b} == target);

  // A forced skip and a natural expiry on the same edge collapse into one advance
  assign hold_expired = tick && (hold_cnt == HOLD_LAST);
  assign advance      = i_enable && (i_next || hold_expired);

  // Sequencer state machine with registered duties, index and step pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      duty_r    <= '0;
      duty_g    <= '0;
      duty_b    <= '0;
      color_idx <= '0;
      hold_cnt  <= '0;
      step      <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        ST_IDLE: begin
          duty_r    <= '0;
          duty_g    <= '0;
          duty_b    <= '0;
          color_idx <= '0;
          hold_cnt  <= '0;
          if (i_enable) begin
            state <= ST_FADE;
          end
        end

        ST_FADE: begin
          if (tick) begin
            duty_r <= next_r;
            duty_g <= next_g;
            duty_b <= next_b;
            step   <= 1'b1;
            if (fade_done) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end
          end
        end

        ST_HOLD: begin
          if (tick) begin
            step <= 1'b1;
          end
          if (advance) begin
            color_idx <= color_idx + IDX_W'(1);
            hold_cnt  <= '0;
            state     <= ST_FADE;
          end else if (tick) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_duty_r    = duty_r;
  assign o_duty_g    = duty_g;
  assign o_duty_b    = duty_b;
  assign o_color_idx = color_idx;
  assign o_state     = state;
  assign o_step      = step;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for rgb_fade_sequencer with TICK_DIV = 4 and
// HOLD_TICKS = 3. Stimulus pushes the expected duty/index/state of each
// step into a queue; a monitor pops one entry per o_step pulse.
module tb_rgb_fade_sequencer;

  localparam int TB_TICK_DIV   = 4;
  localparam int TB_HOLD_TICKS = 3;

  logic       i_clk;
  logic       i_reset;
  logic       i_enable;
  logic       i_next;
  logic [7:0] o_duty_r;
  logic [7:0] o_duty_g;
  logic [7:0] o_duty_b;
  logic [1:0] o_color_idx;
  logic [1:0] o_state;
  logic       o_step;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] idx;
    logic [1:0] st;
  } stepExp_t;

  stepExp_t expQ[$];
  stepExp_t monEntry;
  int       stepsSeen;
  int       checksTotal;
  int       checksPassed;
  int       edgeCount;
  int       baseSteps;

  rgb_fade_sequencer #(
    .TICK_DIV   (TB_TICK_DIV),
    .HOLD_TICKS (TB_HOLD_TICKS)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_next      (i_next),
    .o_duty_r    (o_duty_r),
    .o_duty_g    (o_duty_g),
    .o_duty_b    (o_duty_b),
    .o_color_idx (o_color_idx),
    .o_state     (o_state),
    .o_step      (o_step)
  );

  // Free-running 100 MHz-style clock; period is arbitrary for the bench
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [23:0] paletteRef(input int i);
    case (i % 4)
      0:       return 24'hFF0000;
      1:       return 24'h00FF00;
      2:       return 24'h0000FF;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic nxt);
    i_reset  = rst;
    i_enable = en;
    i_next   = nxt;
  endtask

  // Expected steps for fading from startRgb toward palette[idx], optionally
  // followed by the hold steps ending in the advance to the next colour
  task automatic pushColour(input logic [23:0] startRgb, input int idx,
                            input int nFade, input bit withHold);
    logic [23:0] cur;
    logic [23:0] tgt;
    logic [7:0]  c;
    logic [7:0]  t;
    stepExp_t    e;
    cur = startRgb;
    tgt = paletteRef(idx);
    for (int k = 0; k < nFade; k++) begin
      for (int ch = 0; ch < 3; ch++) begin
        c = cur[8*ch +: 8];
        t = tgt[8*ch +: 8];
        if (c < t) c = c + 8'd1;
        else if (c > t) c = c - 8'd1;
        cur[8*ch +: 8] = c;
      end
      e.r   = cur[23:16];
      e.g   = cur[15:8];
      e.b   = cur[7:0];
      e.idx = 2'(idx);
      e.st  = (cur == tgt) ? 2'd2 : 2'd1;
      expQ.push_back(e);
    end
    if (withHold) begin
      for (int h = 1; h < TB_HOLD_TICKS; h++) begin
        e.idx = 2'(idx);
        e.st  = 2'd2;
        expQ.push_back(e);
      end
      e.idx = 2'((idx + 1) % 4);
      e.st  = 2'd1;
      expQ.push_back(e);
    end
  endtask

  task automatic waitSteps(input int target, input int budget);
    int n;
    n = 0;
    while (stepsSeen < target && n < budget) begin
      @(posedge i_clk);
      #2;
      n++;
    end
    if (stepsSeen < target) begin
      checksTotal++;
      $display("[TB] FAIL waitSteps: got %0d steps, expected %0d within %0d cycles",
               stepsSeen, target, budget);
    end
  endtask

  task automatic countEdgesToStep(output int n, input int budget);
    int base;
    base = stepsSeen;
    n = 0;
    do begin
      @(posedge i_clk);
      #2;
      n++;
    end while (stepsSeen == base && n < budget);
  endtask

  // Monitor: every step pulse consumes one scoreboard entry
  always @(posedge i_clk) begin
    #1;
    if (o_step === 1'b1) begin
      stepsSeen++;
      if (expQ.size() == 0) begin
        checksTotal++;
        $display("[TB] FAIL unexpectedStep: got rgb=%h idx=%0d state=%0d, expected no step",
                 {o_duty_r, o_duty_g, o_duty_b}, o_color_idx, o_state);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("step", 32'({o_duty_r, o_duty_g, o_duty_b, o_color_idx, o_state}),
                    32'(monEntry));
      end
      if (o_color_idx == 2'd2 && o_state == 2'd1) begin
        checkOutput("gbSum", 32'({1'b0, o_duty_g} + {1'b0, o_duty_b}), 32'h0FF);
      end
    end
  end

  initial begin
    stepsSeen    = 0;
    checksTotal  = 0;
    checksPassed = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Reset values
    repeat (3) @(posedge i_clk);
    #2;
    checkOutput("resetDuty", 32'({o_duty_r, o_duty_g, o_duty_b}), 32'h0);
    checkOutput("resetIdx", 32'(o_color_idx), 32'd0);
    checkOutput("resetState", 32'(o_state), 32'd0);
    checkOutput("resetStep", 32'(o_step), 32'd0);

    // Idle with enable low
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (100) @(posedge i_clk);
    #2;
    checkOutput("idleDuty", 32'({o_duty_r, o_duty_g, o_duty_b}), 32'h0);
    checkOutput("idleState", 32'(o_state), 32'd0);
    checkOutput("idleNoStep", 32'(stepsSeen), 32'd0);

    // Full cycle red, green, blue, white, then fade back to red
    pushColour(24'h000000, 0, 255, 1'b1);
    pushColour(24'hFF0000, 1, 255, 1'b1);
    pushColour(24'h00FF00, 2, 255, 1'b1);
    pushColour(24'h0000FF, 3, 255, 1'b1);
    pushColour(24'hFFFFFF, 0, 255, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0);
    countEdgesToStep(edgeCount, 20);
    checkOutput("firstStepLatency", 32'(edgeCount), 32'd5);

    // Freeze mid-fade at R = 80 with the prescaler at 2
    waitSteps(128, 700);
    checkOutput("freezeStartR", 32'(o_duty_r), 32'h80);
    repeat (2) @(posedge i_clk);
    #2;
    applyStimulus(1'b0, 1'b0, 1'b0);
    baseSteps = stepsSeen;
    repeat (50) @(posedge i_clk);
    #2;
    checkOutput("freezeNoStep", 32'(stepsSeen - baseSteps), 32'd0);
    checkOutput("freezeHoldR", 32'(o_duty_r), 32'h80);
    checkOutput("freezeState", 32'(o_state), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    countEdgesToStep(edgeCount, 20);
    checkOutput("resumeLatency", 32'(edgeCount), 32'd2);

    // First HOLD cycle of red after the full cycle: skip with i_next
    waitSteps(1287, 6000);
    checkOutput("preSkipState", 32'(o_state), 32'd2);
    checkOutput("preSkipIdx", 32'(o_color_idx), 32'd0);
    pushColour(24'hFF0000, 1, 255, 1'b1);
    pushColour(24'h00FF00, 2, 64, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(posedge i_clk);
    #2;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("skipIdx", 32'(o_color_idx), 32'd1);
    checkOutput("skipState", 32'(o_state), 32'd1);
    checkOutput("skipNoStep", 32'(o_step), 32'd0);

    // i_next during FADE must be ignored; the scoreboard would catch an advance
    repeat (6) @(posedge i_clk);
    #2;
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (5) @(posedge i_clk);
    #2;
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Reset mid-fade at idx 2 with B = 40, enable held high
    waitSteps(1287 + 258 + 64, 1500);
    checkOutput("preResetB", 32'(o_duty_b), 32'h40);
    checkOutput("preResetIdx", 32'(o_color_idx), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(posedge i_clk);
    #2;
    checkOutput("midResetDuty", 32'({o_duty_r, o_duty_g, o_duty_b}), 32'h0);
    checkOutput("midResetIdx", 32'(o_color_idx), 32'd0);
    checkOutput("midResetState", 32'(o_state), 32'd0);
    checkOutput("midResetStep", 32'(o_step), 32'd0);
    @(posedge i_clk);
    #2;
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushColour(24'h000000, 0, 10, 1'b0);
    @(posedge i_clk);
    #2;
    checkOutput("restartState", 32'(o_state), 32'd1);
    waitSteps(1287 + 258 + 64 + 10, 100);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("restartR", 32'(o_duty_r), 32'h0A);

    repeat (20) @(posedge i_clk);
    #2;
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
